// File: rtl/regfile_cmd_master.sv
// Command sequencer for an external register file: WRITE, dual-port READ2,
// COPY and a 16-cycle CLEAR sweep, with every output driven from a register.
module regfile_cmd_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dst,
    output logic [DATA_W-1:0] rf_data,
    output logic [ADDR_W-1:0] rf_src0,
    output logic [ADDR_W-1:0] rf_src1,
    input  logic [DATA_W-1:0] rf_data0,
    input  logic [DATA_W-1:0] rf_data1,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RSP,
        CP_RD,
        CP_WR,
        CLR
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ2 = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] rf_dst_d, rf_src0_d, rf_src1_d;
    logic [DATA_W-1:0] rf_data_d, rsp_data0_d, rsp_data1_d;
    logic              rf_we_d, rsp_valid_d, cmd_ready_d, busy_d;

    always_comb begin
        state_d     = state_q;
        addr_a_d    = addr_a_q;
        clr_cnt_d   = clr_cnt_q;
        rf_we_d     = 1'b0;
        rf_dst_d    = rf_dst;
        rf_data_d   = rf_data;
        rf_src0_d   = rf_src0;
        rf_src1_d   = rf_src1;
        rsp_valid_d = 1'b0;
        rsp_data0_d = rsp_data0;
        rsp_data1_d = rsp_data1;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_a_d = cmd_addr_a;
                    case (cmd_op)
                        OP_WRITE: begin
                            state_d   = WR;
                            rf_we_d   = 1'b1;
                            rf_dst_d  = cmd_addr_a;
                            rf_data_d = cmd_wdata;
                        end
                        OP_READ2: begin
                            state_d   = RD;
                            rf_src0_d = cmd_addr_a;
                            rf_src1_d = cmd_addr_b;
                        end
                        OP_COPY: begin
                            state_d   = CP_RD;
                            rf_src0_d = cmd_addr_b;
                        end
                        default: begin
                            state_d   = CLR;
                            rf_we_d   = 1'b1;
                            rf_dst_d  = '0;
                            rf_data_d = '0;
                            clr_cnt_d = '0;
                        end
                    endcase
                end
            end
            WR: state_d = IDLE;
            RD: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data0_d = rf_data0;
                rsp_data1_d = rf_data1;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            CP_RD: begin
                state_d   = CP_WR;
                rf_we_d   = 1'b1;
                rf_dst_d  = addr_a_q;
                rf_data_d = rf_data0;
            end
            CP_WR: state_d = IDLE;
            CLR: begin
                // Counter wraps to 0 on the last sweep cycle so it reads 0 in IDLE.
                clr_cnt_d = ADDR_W'(clr_cnt_q + 1'b1);
                if (clr_cnt_q == '1) begin
                    state_d = IDLE;
                end else begin
                    rf_we_d  = 1'b1;
                    rf_dst_d = clr_cnt_d;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = !cmd_ready_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_a_q  <= '0;
            clr_cnt_q <= '0;
            rf_we     <= 1'b0;
            rf_dst    <= '0;
            rf_data   <= '0;
            rf_src0   <= '0;
            rf_src1   <= '0;
            rsp_valid <= 1'b0;
            rsp_data0 <= '0;
            rsp_data1 <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_a_q  <= addr_a_d;
            clr_cnt_q <= clr_cnt_d;
            rf_we     <= rf_we_d;
            rf_dst    <= rf_dst_d;
            rf_data   <= rf_data_d;
            rf_src0   <= rf_src0_d;
            rf_src1   <= rf_src1_d;
            rsp_valid <= rsp_valid_d;
            rsp_data0 <= rsp_data0_d;
            rsp_data1 <= rsp_data1_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Bench for regfile_cmd_master: behavioural register file, write/response
// scoreboard queues and directed cycle-accurate checks.
module tb_regfile_cmd_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr_a, cmd_addr_b;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data0, rsp_data1;
    logic       rf_we;
    logic [3:0] rf_dst, rf_src0, rf_src1;
    logic [7:0] rf_data, rf_data0, rf_data1;
    logic       busy;

    logic [7:0]  rf_mem [16];
    logic [11:0] exp_wr[$];
    logic [15:0] exp_rsp[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_cmd_master #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data),
        .rf_src0(rf_src0), .rf_src1(rf_src1),
        .rf_data0(rf_data0), .rf_data1(rf_data1),
        .busy(busy)
    );

    assign rf_data0 = rf_mem[rf_src0];
    assign rf_data1 = rf_mem[rf_src1];

    always @(posedge clk) if (rf_we) rf_mem[rf_dst] <= rf_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation on each write pulse / response handshake.
    always @(negedge clk) begin
        logic [11:0] w;
        logic [15:0] r;
        if (rf_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL wr_unexpected: got dst=%0d data=%0h required no write", rf_dst, rf_data);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_dst", 32'(rf_dst), 32'(w[11:8]));
                chk("wr_data", 32'(rf_data), 32'(w[7:0]));
            end
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_rsp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rsp_unexpected: got %0h/%0h required no response", rsp_data0, rsp_data1);
            end else begin
                r = exp_rsp.pop_front();
                chk("rsp_data0", 32'(rsp_data0), 32'(r[15:8]));
                chk("rsp_data1", 32'(rsp_data1), 32'(r[7:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offers a command, waits for accept; returns #1 into cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] wd, output int waits);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = wd;
        waits = 0;
        while (!cmd_ready && waits < 100) begin
            step();
            waits++;
        end
        chk("accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        int w;
        exp_wr.push_back({a, d});
        issue(2'b00, a, 4'd0, d, w);
        step();
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [7:0] e0, input logic [7:0] e1);
        int w;
        rsp_ready = 1'b1;
        exp_rsp.push_back({e0, e1});
        issue(2'b01, a, b, 8'd0, w);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_a = '0; cmd_addr_b = '0;
        cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rf_dst", 32'(rf_dst), 0);
        chk("rst_rf_data", 32'(rf_data), 0);
        chk("rst_rf_src", 32'({rf_src0, rf_src1}), 0);
        chk("rst_rsp_data", 32'({rsp_data0, rsp_data1}), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // WRITE 5 <= A7
        exp_wr.push_back({4'd5, 8'hA7});
        issue(2'b00, 4'd5, 4'd0, 8'hA7, w);
        chk("wr_t1_we", 32'(rf_we), 1);
        chk("wr_t1_dst", 32'(rf_dst), 5);
        chk("wr_t1_data", 32'(rf_data), 32'hA7);
        chk("wr_t1_busy", 32'(busy), 1);
        step();
        chk("wr_t2_we", 32'(rf_we), 0);
        chk("wr_t2_ready", 32'(cmd_ready), 1);

        wr(4'd3, 8'h11);
        wr(4'd9, 8'h22);
        wr(4'd2, 8'h5C);

        // READ2 with the response held off for four cycles
        rsp_ready = 1'b0;
        exp_rsp.push_back({8'h11, 8'h22});
        issue(2'b01, 4'd3, 4'd9, 8'd0, w);
        chk("rd_t1_src0", 32'(rf_src0), 3);
        chk("rd_t1_src1", 32'(rf_src1), 9);
        chk("rd_t1_valid", 32'(rsp_valid), 0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("rsp_hold_valid", 32'(rsp_valid), 1);
            chk("rsp_hold_d0", 32'(rsp_data0), 32'h11);
            chk("rsp_hold_d1", 32'(rsp_data1), 32'h22);
            chk("rsp_hold_ready", 32'(cmd_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        chk("rsp_hs_valid", 32'(rsp_valid), 1);
        step();
        chk("rsp_done_valid", 32'(rsp_valid), 0);
        chk("rsp_done_ready", 32'(cmd_ready), 1);
        rsp_ready = 1'b0;

        // COPY 7 <= reg 2
        exp_wr.push_back({4'd7, 8'h5C});
        issue(2'b10, 4'd7, 4'd2, 8'd0, w);
        chk("cp_t1_src0", 32'(rf_src0), 2);
        chk("cp_t1_we", 32'(rf_we), 0);
        step();
        chk("cp_t2_we", 32'(rf_we), 1);
        chk("cp_t2_dst", 32'(rf_dst), 7);
        chk("cp_t2_data", 32'(rf_data), 32'h5C);
        step();
        chk("cp_t3_ready", 32'(cmd_ready), 1);

        // READ2 with rsp_ready already high, then back-to-back WRITE
        rsp_ready = 1'b1;
        exp_rsp.push_back({8'h5C, 8'h5C});
        issue(2'b01, 4'd7, 4'd2, 8'd0, w);
        step();
        chk("rd_fast_t2_valid", 32'(rsp_valid), 1);
        step();
        chk("rd_fast_t3_valid", 32'(rsp_valid), 0);
        chk("rd_fast_t3_ready", 32'(cmd_ready), 1);
        exp_wr.push_back({4'd6, 8'h99});
        issue(2'b00, 4'd6, 4'd0, 8'h99, w);
        chk("b2b_waits", 32'(w), 0);
        chk("b2b_we", 32'(rf_we), 1);
        chk("b2b_dst", 32'(rf_dst), 6);
        step();

        // COPY onto itself
        wr(4'd4, 8'h3D);
        exp_wr.push_back({4'd4, 8'h3D});
        issue(2'b10, 4'd4, 4'd4, 8'd0, w);
        chk("cpself_src0", 32'(rf_src0), 4);
        step();
        chk("cpself_data", 32'(rf_data), 32'h3D);
        step();

        // CLEAR with another command held pending throughout
        for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 8'h00});
        exp_wr.push_back({4'd1, 8'h00});
        issue(2'b11, 4'd0, 4'd0, 8'd0, w);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr_a = 4'd1; cmd_wdata = 8'h00;
        for (int i = 0; i < 16; i++) begin
            chk("clr_we", 32'(rf_we), 1);
            chk("clr_dst", 32'(rf_dst), 32'(i));
            chk("clr_data", 32'(rf_data), 0);
            chk("clr_ready", 32'(cmd_ready), 0);
            step();
        end
        chk("clr_t17_ready", 32'(cmd_ready), 1);
        chk("clr_t17_we", 32'(rf_we), 0);
        step();
        cmd_valid = 1'b0;
        chk("clr_held_we", 32'(rf_we), 1);
        chk("clr_held_dst", 32'(rf_dst), 1);
        step();
        for (int i = 0; i < 16; i += 2) rd(4'(i), 4'(i + 1), 8'h00, 8'h00);

        // Reset on the 8th CLEAR cycle
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_wr.push_back({4'(i), 8'h00});
        issue(2'b11, 4'd0, 4'd0, 8'd0, w);
        repeat (7) step();
        chk("clr8_dst", 32'(rf_dst), 7);
        rst_n = 1'b0;
        step();
        chk("clr_rst_we", 32'(rf_we), 0);
        chk("clr_rst_busy", 32'(busy), 0);
        chk("clr_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("clr_rst_dst", 32'(rf_dst), 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 8'h00});
        issue(2'b11, 4'd0, 4'd0, 8'd0, w);
        for (int i = 0; i < 16; i++) begin
            chk("clr2_dst", 32'(rf_dst), 32'(i));
            step();
        end
        chk("clr2_ready", 32'(cmd_ready), 1);

        // Reset with a response pending drops it
        wr(4'd8, 8'hE1);
        issue(2'b01, 4'd8, 4'd8, 8'd0, w);
        step();
        chk("rsp_pend_valid", 32'(rsp_valid), 1);
        chk("rsp_pend_data", 32'(rsp_data0), 32'hE1);
        rst_n = 1'b0;
        step();
        chk("rsp_rst_valid", 32'(rsp_valid), 0);
        chk("rsp_rst_data", 32'(rsp_data0), 0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("rsp_rst_ready", 32'(cmd_ready), 1);

        chk("wr_queue_empty", 32'(exp_wr.size()), 0);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_cmd_master.md
REGFILE_CMD_MASTER -- requirements
Module: regfile_cmd_master

Interface
REQ-001 Parameter DATA_W, default 8: register data width.
REQ-002 Parameter ADDR_W, default 4: register address width; the block covers 2**ADDR_W = 16 registers.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted on the cycle where cmd_valid && cmd_ready.
REQ-007 cmd_op  input  2  command: 00 WRITE, 01 READ2, 10 COPY, 11 CLEAR.
REQ-008 cmd_addr_a  input  ADDR_W  WRITE/COPY destination; READ2 port-0 address.
REQ-009 cmd_addr_b  input  ADDR_W  COPY source; READ2 port-1 address.
REQ-010 cmd_wdata  input  DATA_W  WRITE data.
REQ-011 rsp_valid  output  1  READ2 response pending.
REQ-012 rsp_ready  input  1  response consumed on the cycle where rsp_valid && rsp_ready.
REQ-013 rsp_data0, rsp_data1  output  DATA_W each  READ2 results for addr_a and addr_b.
REQ-014 rf_we  output  1  register-file write enable.
REQ-015 rf_dst  output  ADDR_W  register-file write address.
REQ-016 rf_data  output  DATA_W  register-file write data.
REQ-017 rf_src0, rf_src1  output  ADDR_W each  register-file read addresses.
REQ-018 rf_data0, rf_data1  input  DATA_W each  combinational register-file read data for rf_src0 and rf_src1.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, WR, RD, RSP, CP_RD, CP_WR and CLR.
REQ-021 All outputs SHALL be driven from registers.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command is accepted only in IDLE.
REQ-023 Every command field SHALL be latched on the accept cycle T.
REQ-024 WRITE: state WR at T+1 with rf_we=1, rf_dst=addr_a, rf_data=wdata; return to IDLE at T+2.
REQ-025 READ2: state RD at T+1 with rf_src0=addr_a and rf_src1=addr_b.
REQ-026 READ2: at the end of T+1, rf_data0 and rf_data1 SHALL be captured into rsp_data0 and rsp_data1.
REQ-027 READ2: state RSP with rsp_valid=1 from T+2.
REQ-028 In RSP, rsp_valid and rsp_data SHALL hold stable until rsp_ready; the FSM returns to IDLE on the cycle after the handshake.
REQ-029 If rsp_ready is already 1 at T+2, rsp_valid SHALL be high for exactly one cycle and cmd_ready SHALL return at T+3.
REQ-030 COPY: state CP_RD at T+1 with rf_src0=addr_b; rf_data0 is captured at the end of T+1.
REQ-031 COPY: state CP_WR at T+2 with rf_we=1, rf_dst=addr_a, rf_data=captured value; IDLE at T+3.
REQ-032 COPY with addr_a == addr_b SHALL rewrite the unchanged value.
REQ-033 CLEAR: state CLR from T+1 to T+16, driving rf_we=1, rf_data=0 and rf_dst = a 4-bit counter running 0,1,...,15.
REQ-034 CLEAR: IDLE SHALL be re-entered at T+17 when the counter wraps from 15 to 0; the counter SHALL read 0 in IDLE.
REQ-035 rf_we SHALL be 1 only in WR, CP_WR and CLR, for exactly one cycle per write.
REQ-036 rf_dst, rf_data, rf_src0 and rf_src1 SHALL hold their last values when not in use.
REQ-037 cmd_valid is ignored outside IDLE; commands are not queued.
REQ-038 rsp_ready is ignored outside RSP.
REQ-039 busy SHALL equal !cmd_ready.

Reset
REQ-040 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and all of the following SHALL be 0: rf_we, rsp_valid, busy, rf_dst, rf_data, rf_src0, rf_src1, rsp_data0, rsp_data1 and the CLEAR counter.
REQ-041 cmd_ready SHALL be 1 on the first cycle after reset is released.
REQ-042 Reset mid-operation (for example, during CLR or RSP) SHALL abort the command with no further rf_we pulse and drop any pending response.

Verification
REQ-043 WRITE op=00, a=5, wdata=0xA7 -> rf_we=1, rf_dst=5, rf_data=0xA7 at T+1 only; cmd_ready=1 at T+2.
REQ-044 Registers 3=0x11 and 9=0x22, then READ2 a=3, b=9 with rsp_ready held 0 for 4 cycles -> rsp_valid=1 from T+2 with rsp_data0=0x11 and rsp_data1=0x22 stable; IDLE one cycle after rsp_ready.
REQ-045 Register 2=0x5C, then COPY a=7, b=2 -> rf_src0=2 at T+1; rf_we=1, rf_dst=7, rf_data=0x5C at T+2; a following READ2 of register 7 returns 0x5C.
REQ-046 CLEAR -> 16 consecutive rf_we pulses with rf_dst 0..15 and rf_data=0; cmd_valid held high during CLR is not accepted until T+17; every register reads 0 afterwards.
REQ-047 rst_n=0 at the 8th CLR cycle -> rf_we=0 on the next cycle, FSM in IDLE, counter 0, rsp_valid=0.
REQ-048 READ2 with rsp_ready=1 constantly -> rsp_valid is a single-cycle pulse at T+2 and a back-to-back command is accepted at T+3.
